correlate_source: RTL
=====================

Name: correlate_source

Overview:
Produces the per-sample input stream for one `correlate` lane. It takes packed antenna I/Q sample words from the capture path and selects one antenna pair per accumulation window. It emits the 4-bit {ai,aq,bi,bq} beat stream with valid/first/last/auto framing. Sits between the sample buffer and a correlator instance, so the correlator sees well-formed windows of exactly COUNT beats.

Parameters:
WIDTH, 8, number of antennas per sample word; power of two, >= 2
COUNT, 256, samples per accumulation window; >= 1
ABITS, log2(WIDTH), antenna index width (derived, localparam)
CBITS, log2(COUNT)+1, window beat-counter width (derived, localparam)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable_i  in  1  start/continue windowing; sampled at window boundaries
pair_a_i  in  ABITS  antenna index driving ai/aq; latched at window start
pair_b_i  in  ABITS  antenna index driving bi/bq; latched at window start
s_valid_i  in  1  sample word valid
s_ready_o  out  1  sample word accepted when s_valid_i & s_ready_o
s_data_i  in  2*WIDTH  antenna k: I at bit 2k+1, Q at bit 2k
valid_o  out  1  beat valid (no backpressure downstream)
first_o  out  1  first beat of window
last_o  out  1  last beat of window
auto_o  out  1  high when latched pair_a == pair_b
ai_o, aq_o, bi_o, bq_o  out  1 each  selected sample bits
busy_o  out  1  high while a window is open

Behaviour:
- Reset (async assert, sync deassert expected upstream): state=IDLE, count=0, all outputs 0, s_ready_o=0.
- States:
  - IDLE: s_ready_o=0. If enable_i=1, latch pair_a_i/pair_b_i, clear count, go to RUN on the next edge.
  - RUN: s_ready_o=1. Each accepted word increments count. On the accepted word where count==COUNT-1, go to IDLE if enable_i=0, else stay in RUN with the pair re-latched and count cleared (back-to-back windows, no bubble).
- enable_i deasserted mid-window: the window always completes all COUNT beats. There are no truncated windows, and last_o is always delivered.
- Pair inputs changing mid-window are ignored until the next latch.
- Output timing:
  - Outputs are registered; an accepted word at edge t appears on the outputs after edge t.
  - Latency 1 cycle.
  - valid_o=0 in any cycle with no accepted word; first_o, last_o and the data bits are held at 0 when valid_o=0.
- first_o=1 on the beat with count==0; last_o=1 on the beat with count==COUNT-1. COUNT=1: first_o and last_o are both high on every beat.
- Input stalls (s_valid_i=0) inside a window produce valid_o gaps. count does not advance, and first/last remain correctly placed on the valid beats.
- auto_o follows the latched pair, constant for the window, and is qualified by valid_o.
- busy_o=1 from the IDLE->RUN transition until the edge after the last beat is output.
- Counter arithmetic: unsigned CBITS; count never exceeds COUNT-1 (it wraps to 0 at window end).
- Reset mid-window aborts immediately; no last_o is issued. The downstream correlator is reset by the same domain reset.

Optional Feature:
Macro CORRELATE_SOURCE_TAG_EN.
- Defined: adds output window_o [15:0], a count of completed windows.
  - Increments on each last_o beat and wraps 0xFFFF->0.
  - Its value is stable and valid alongside the whole window it tags: it holds the index of the current window while first..last are output.
  - Reset to 0.
- Undefined: port and counter absent; no other behaviour changes.

Test Plan:
- COUNT=4, enable_i=1, pair_a=2, pair_b=5, continuous s_valid_i with s_data_i=16'h0030 -> four valid beats.
  - ai=1, aq=1, bi=0, bq=0 on every beat.
  - first_o only on beat 0, last_o only on beat 3, auto_o=0.
- Same setup, s_valid_i toggled 1,0,1,1,0,1 -> exactly 4 valid beats with gaps mirroring the stalls; first on beat 0, last on beat 3.
- pair_a=pair_b=3 -> auto_o=1 on all beats; ai==bi and aq==bq each beat.
- enable_i dropped after beat 1 of 4 -> beats 2,3 still produced, last_o on beat 3, then s_ready_o=0 and busy_o=0 one cycle after.
- enable_i held, pair changed 1->6 mid-window -> beats of that window use antenna 1; the next window starts with no bubble and uses 6.
- COUNT=1, three accepted words -> three beats, each with first_o=last_o=1.
  - With CORRELATE_SOURCE_TAG_EN defined: window_o reads 0,1,2 on those beats.
- reset_n pulsed low during beat 2 -> all outputs 0 the same cycle, state IDLE, count 0.

Source files
------------

// File: rtl/correlate_source.sv
// Per-lane correlator feeder: picks one antenna pair per COUNT-beat window and
// emits framed {ai,aq,bi,bq} beats. Optional window tag: CORRELATE_SOURCE_TAG_EN.
module correlate_source #(
  parameter  int WIDTH = 8,
  parameter  int COUNT = 256,
  localparam int ABITS = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic [ABITS-1:0]   pair_a_i,
  input  logic [ABITS-1:0]   pair_b_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [2*WIDTH-1:0] s_data_i,
  output logic               valid_o,
  output logic               first_o,
  output logic               last_o,
  output logic               auto_o,
  output logic               ai_o,
  output logic               aq_o,
  output logic               bi_o,
  output logic               bq_o,
  output logic               busy_o
`ifdef CORRELATE_SOURCE_TAG_EN
  ,
  output logic [15:0]        window_o
`endif
);

  localparam int CBITS = $clog2(COUNT) + 1;
  localparam logic [CBITS-1:0] LAST_CNT = CBITS'(COUNT - 1);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("correlate_source: WIDTH must be a power of two >= 2");
  end
  if (COUNT < 1) begin : g_bad_count
    $error("correlate_source: COUNT must be >= 1");
  end

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [ABITS-1:0] r_pair_a;
  logic [ABITS-1:0] r_pair_b;
  logic [CBITS-1:0] r_count;
  logic             r_valid;
  logic             r_first;
  logic             r_last;
  logic             r_auto;
  logic             r_ai;
  logic             r_aq;
  logic             r_bi;
  logic             r_bq;
  logic             r_busy;

  logic             w_accept;
  logic             w_at_last;
  logic [ABITS:0]   w_ai_idx;
  logic [ABITS:0]   w_aq_idx;
  logic [ABITS:0]   w_bi_idx;
  logic [ABITS:0]   w_bq_idx;

  assign s_ready_o = (r_state == S_RUN);
  assign w_accept  = s_valid_i & s_ready_o;
  assign w_at_last = (r_count == LAST_CNT);
  assign w_ai_idx  = {r_pair_a, 1'b1};
  assign w_aq_idx  = {r_pair_a, 1'b0};
  assign w_bi_idx  = {r_pair_b, 1'b1};
  assign w_bq_idx  = {r_pair_b, 1'b0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_pair_a <= '0;
      r_pair_b <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_auto   <= 1'b0;
      r_ai     <= 1'b0;
      r_aq     <= 1'b0;
      r_bi     <= 1'b0;
      r_bq     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_first <= w_accept & (r_count == '0);
      r_last  <= w_accept & w_at_last;
      r_auto  <= w_accept & (r_pair_a == r_pair_b);
      r_ai    <= w_accept & s_data_i[w_ai_idx];
      r_aq    <= w_accept & s_data_i[w_aq_idx];
      r_bi    <= w_accept & s_data_i[w_bi_idx];
      r_bq    <= w_accept & s_data_i[w_bq_idx];

      unique case (r_state)
        S_IDLE: begin
          r_busy <= enable_i;
          if (enable_i) begin
            r_pair_a <= pair_a_i;
            r_pair_b <= pair_b_i;
            r_count  <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          // busy stays up through the cycle that presents the final beat
          r_busy <= 1'b1;
          if (w_accept) begin
            if (w_at_last) begin
              r_count <= '0;
              if (enable_i) begin
                r_pair_a <= pair_a_i;
                r_pair_b <= pair_b_i;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_count <= r_count + CBITS'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CORRELATE_SOURCE_TAG_EN
  logic [15:0] r_window;

  // advance after the last beat has been shown, so the tag spans first..last
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_window <= '0;
    end else if (r_last) begin
      r_window <= r_window + 16'd1;
    end
  end

  assign window_o = r_window;
`endif

  assign valid_o = r_valid;
  assign first_o = r_first;
  assign last_o  = r_last;
  assign auto_o  = r_auto;
  assign ai_o    = r_ai;
  assign aq_o    = r_aq;
  assign bi_o    = r_bi;
  assign bq_o    = r_bq;
  assign busy_o  = r_busy;

endmodule
